// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified-memory port arbiter.
package mem_arb_pkg;
  localparam int AW_DEF         = 32;
  localparam int DW_DEF         = 32;
  localparam int MAX_DBURST_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} arb_state_t;
  typedef enum logic {PORT_I, PORT_D} port_sel_t;
endpackage

// File: rtl/mem_arb_watchdog.sv
// Loadable up-counter with clear and enable; o_tc flags the count at TIMEOUT.
module mem_arb_watchdog #(
  parameter int  TIMEOUT = 255,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_tc
);
  logic [CW-1:0] r_cnt;

  assign o_tc = (r_cnt == CW'(TIMEOUT));

  // Clear beats load beats increment; the count parks at terminal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             r_cnt <= '0;
    else if (i_clr)         r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (i_en && !o_tc) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-ported, variable-latency memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MAX_DBURST = MAX_DBURST_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wmask,
  input  logic            m_ack,
  input  logic [DW-1:0]   m_rdata,
  output logic            err,
  output logic [31:0]     wait_cycles
);
  localparam int BW = $clog2(MAX_DBURST + 2);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t      r_state, w_state_nxt;
  logic [BW-1:0]   r_burst, w_burst_nxt;
  logic            r_req, w_req_nxt;
  logic            r_we, w_we_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [DW-1:0]   r_wdata, w_wdata_nxt;
  logic [DW/8-1:0] r_wmask, w_wmask_nxt;
  logic            r_err;
  logic [31:0]     r_wait;

  logic      w_gnt, w_burst_max, w_busy, w_load, w_clr, w_abort, w_wd_tc, w_wait_inc;
  port_sel_t w_sel;

  assign w_busy      = (r_state != IDLE);
  assign w_burst_max = (r_burst == BW'(MAX_DBURST));

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (CW'(1)),
    .i_en       (w_busy),
    .o_tc       (w_wd_tc)
  );

  // Data wins unless fetch has already waited out MAX_DBURST data grants.
  always_comb begin
    w_gnt = 1'b0;
    w_sel = PORT_I;
    if (d_req && (!w_burst_max || !i_req)) begin
      w_gnt = 1'b1;
      w_sel = PORT_D;
    end else if (i_req) begin
      w_gnt = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_wmask_nxt = r_wmask;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt) begin
          w_req_nxt = 1'b1;
          w_load    = 1'b1;
          if (w_sel == PORT_D) begin
            w_state_nxt = DBUSY;
            w_we_nxt    = d_we;
            w_addr_nxt  = d_addr;
            w_wdata_nxt = d_wdata;
            w_wmask_nxt = d_we ? d_wmask : '0;
            w_burst_nxt = i_req ? BW'(r_burst + 1'b1) : '0;
          end else begin
            w_state_nxt = IBUSY;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = i_addr;
            w_wdata_nxt = '0;
            w_wmask_nxt = '0;
            w_burst_nxt = '0;
          end
        end
      end
      IBUSY, DBUSY: begin
        if (m_ack) begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          w_clr       = 1'b1;
        end else if (w_wd_tc) begin
          // Hung access: abandon it silently; requester stays stalled.
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          w_clr       = 1'b1;
          w_abort     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_burst <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_wmask <= w_wmask_nxt;
    end
  end

  assign w_wait_inc = (i_req && !i_ready) || (d_req && !d_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err  <= 1'b0;
      r_wait <= '0;
    end else begin
      if (w_abort) r_err <= 1'b1;
      if (w_wait_inc && (r_wait != 32'hFFFF_FFFF)) r_wait <= r_wait + 32'd1;
    end
  end

  // Ready is gated by state so a stray ack in IDLE is dropped.
  assign i_ready     = (r_state == IBUSY) && m_ack;
  assign d_ready     = (r_state == DBUSY) && m_ack;
  assign i_rdata     = m_rdata;
  assign d_rdata     = m_rdata;
  assign m_req       = r_req;
  assign m_we        = r_we;
  assign m_addr      = r_addr;
  assign m_wdata     = r_wdata;
  assign m_wmask     = r_wmask;
  assign err         = r_err;
  assign wait_cycles = r_wait;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory responder.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32;

  logic            clk = 1'b0, reset = 1'b0;
  logic            i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0]   i_addr = '0, d_addr = '0;
  logic [DW-1:0]   d_wdata = '0;
  logic [DW/8-1:0] d_wmask = '0;
  logic [DW-1:0]   i_rdata, d_rdata, m_wdata;
  logic            i_ready, d_ready, m_req, m_we, err;
  logic [AW-1:0]   m_addr;
  logic [DW/8-1:0] m_wmask;
  logic            m_ack = 1'b0;
  logic [DW-1:0]   m_rdata = '0;
  logic [31:0]     wait_cycles;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DBURST(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err), .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Memory model: acks in the ack_at-th cycle of a held m_req; man_ack injects a stray ack.
  bit          mem_en = 1'b0, man_ack = 1'b0;
  int          ack_at = 1, bcnt = 0;
  logic [DW-1:0] mem_data = '0;
  always @(negedge clk) begin
    if (m_req) bcnt++;
    else       bcnt = 0;
    m_ack   = man_ack || (mem_en && m_req && bcnt == ack_at);
    m_rdata = mem_data;
  end

  task automatic nxt();    @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); #1; endtask

  int np, nb, ng, nbad, both;
  bit done, prev;
  logic [31:0] got, w0;
  logic [5:0]  gseq;

  initial begin
    repeat (2) @(posedge clk);
    sample();
    chk("rst m_req", m_req, 0);
    chk("rst m_addr", m_addr, 0);
    chk("rst err", err, 0);
    chk("rst wait", wait_cycles, 0);
    chk("rst ready", {i_ready, d_ready}, 0);
    nxt(); reset = 1'b1;

    // Idle for 100 cycles
    nb = 0;
    for (int k = 0; k < 100; k++) begin sample(); if (m_req) nb++; end
    chk("idle m_req", nb, 0);
    chk("idle wait", wait_cycles, 0);

    // Single fetch, ack in first busy cycle
    mem_en = 1'b1; ack_at = 1; mem_data = 32'h0050_0093;
    nxt(); i_req = 1'b1; i_addr = 32'h10;
    sample(); chk("t1 c0 m_req", m_req, 0);
    nxt(); sample();
    chk("t1 c1 m_req", m_req, 1);
    chk("t1 c1 m_addr", m_addr, 32'h10);
    chk("t1 c1 i_ready", i_ready, 1);
    chk("t1 c1 i_rdata", i_rdata, 32'h0050_0093);
    chk("t1 c1 d_ready", d_ready, 0);
    nxt(); i_req = 1'b0; sample();
    chk("t1 c2 m_req", m_req, 0);
    chk("t1 c2 i_ready", i_ready, 0);
    chk("t1 wait", wait_cycles, 1);

    // Load with ack in the fifth busy cycle
    ack_at = 5; mem_data = 32'h1234_5678;
    nxt(); w0 = wait_cycles; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1004; d_wmask = 4'hF;
    np = 0; got = '0; nbad = 0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (m_req && (m_addr !== 32'h1004 || m_we !== 1'b0 || m_wmask !== 4'h0)) nbad++;
      if (d_ready) begin np++; got = d_rdata; end
      nxt();
      if (np != 0) d_req = 1'b0;
    end
    chk("t3 pulses", np, 1);
    chk("t3 rdata", got, 32'h1234_5678);
    chk("t3 mfields", nbad, 0);
    chk("t3 wait delta", wait_cycles - w0, 5);

    // Contention: stores and fetches held together
    ack_at = 2;
    nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'hF;
    i_req = 1'b1; i_addr = 32'h40;
    prev = 1'b0; ng = 0; gseq = '0; nbad = 0; both = 0;
    for (int k = 0; k < 80 && ng < 6; k++) begin
      sample();
      if (i_ready && d_ready) both++;
      if (m_req && !prev) begin
        ng++;
        gseq = {gseq[4:0], m_we};
        if (m_we && (m_wdata !== 32'hDEAD_BEEF || m_wmask !== 4'hF || m_addr !== 32'h2000)) nbad++;
        if (!m_we && (m_addr !== 32'h40 || m_wmask !== 4'h0)) nbad++;
      end
      prev = m_req;
      nxt();
    end
    chk("t2 grants", ng, 6);
    chk("t2 order", gseq, 6'b111101);
    chk("t2 fields", nbad, 0);
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (i_ready && d_ready) both++;
      if (d_ready) begin done = 1'b1; break; end
      nxt();
    end
    chk("t2 last done", done, 1);
    chk("t2 one ready", both, 0);
    nxt(); i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    // Watchdog abort on a fetch that never completes
    mem_en = 1'b0;
    nxt(); i_req = 1'b1; i_addr = 32'h80;
    nb = 0; np = 0; done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      sample();
      if (i_ready) np++;
      if (m_req) nb++;
      else if (nb > 0) begin i_req = 1'b0; done = 1'b1; break; end
      nxt();
    end
    chk("t4 aborted", done, 1);
    chk("t4 busy cycles", nb, 8);
    chk("t4 no ready", np, 0);
    chk("t4 err", err, 1);
    repeat (3) nxt();
    sample();
    chk("t4 idle m_req", m_req, 0);
    nxt(); man_ack = 1'b1; sample();
    chk("t4 late ack ready", {i_ready, d_ready}, 0);
    nxt(); man_ack = 1'b0; sample();
    chk("t4 err sticky", err, 1);

    // Asynchronous reset in the middle of a store
    nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'h55; d_wmask = 4'h3;
    sample(); nxt(); sample();
    chk("t5 busy m_req", m_req, 1);
    chk("t5 busy wmask", m_wmask, 4'h3);
    #2 reset = 1'b0;
    #1;
    chk("t5 rst m_req", m_req, 0);
    chk("t5 rst d_ready", d_ready, 0);
    chk("t5 rst err", err, 0);
    chk("t5 rst wait", wait_cycles, 0);
    d_req = 1'b0; d_we = 1'b0;
    nxt(); nxt(); reset = 1'b1;
    mem_en = 1'b1; ack_at = 1; mem_data = 32'hCAFE_F00D;
    nxt(); i_req = 1'b1; i_addr = 32'h100;
    done = 1'b0; got = '0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (i_ready) begin done = 1'b1; got = i_rdata; break; end
      nxt();
    end
    nxt(); i_req = 1'b0;
    chk("t5 fetch done", done, 1);
    chk("t5 fetch rdata", got, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port (F stage) and data port (M stage). This is the unified-memory configuration of the 5-stage core.
- Grants one transaction at a time, with data priority and a starvation guard for fetch.
- Returns per-port ready pulses; the pipeline derives its stall from these.
- Includes a watchdog that aborts hung memory transactions, and a wait-cycle counter for profiling.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MAX_DBURST, 4, consecutive data grants allowed while fetch waits; the next grant is then forced to fetch.
- TIMEOUT, 255, cycles in BUSY without m_ack before abort.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_ready.
- i_addr  in  AW  fetch address, word aligned.
- i_rdata  out  DW  fetch data, valid when i_ready=1.
- i_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  load/store request; held with d_we, d_addr, d_wdata, d_wmask until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_wmask  in  DW/8  byte enables for stores.
- d_rdata  out  DW  load data, valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- m_req  out  1  memory request; held stable until m_ack.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_wmask  out  DW/8  memory byte enables; all zeros for reads.
- m_ack  in  1  one-cycle completion from memory; m_rdata valid in the same cycle.
- m_rdata  in  DW  memory read data.
- err  out  1  sticky; set on watchdog abort, cleared only by reset.
- wait_cycles  out  32  count of cycles with a request pending and not completing.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; m_req=0, m_we=0, m_addr=0, m_wdata=0, m_wmask=0.
  - i_ready=0, d_ready=0; err=0; wait_cycles=0; burst count=0; watchdog=0.
- States: IDLE, IBUSY, DBUSY.
- IDLE:
  - If d_req and (burst<MAX_DBURST or !i_req): go to DBUSY and latch data-side fields into the m_* registers; if i_req, burst++, else burst=0.
  - Else if i_req: go to IBUSY, latch i_addr; m_we=0, m_wmask=0; burst=0.
  - Else stay in IDLE.
  - m_req goes high on the edge that enters a BUSY state, so memory sees the request 1 cycle after grant.
- IBUSY/DBUSY:
  - m_* registers are held constant; watchdog increments each cycle.
  - On m_ack: the matching ready is pulsed combinationally in the same cycle; rdata passes through combinationally from m_rdata. Then m_req=0, watchdog=0, state goes to IDLE.
  - m_rdata is ignored for stores, but d_ready still pulses.
- Minimum transaction: grant cycle plus ack cycle, so 2 cycles with zero-latency memory. Back-to-back requests are re-arbitrated in IDLE on every grant.
- Simultaneous i_req and d_req: data wins (it belongs to the older instruction), except when burst==MAX_DBURST, where fetch is granted and burst is cleared.
- Watchdog: when watchdog reaches TIMEOUT in BUSY with no m_ack:
  - drop m_req, set err=1, go to IDLE;
  - the pending port receives no ready pulse and its requester stays stalled, which is intentional and visible to the bench.
- m_ack received in IDLE (late ack after an abort, or after reset) is ignored; no ready pulse.
- Requester deasserting req mid-transaction is a protocol violation. The transaction still completes and its ready pulses; no assertion is required in RTL.
- Only one of i_ready and d_ready may be high in any cycle.
- wait_cycles increments every cycle in which (i_req & !i_ready) | (d_req & !d_ready). It saturates at 32'hFFFFFFFF, with no wrap.
- Reset asserted mid-transaction: immediate return to IDLE with m_req=0; a late m_ack from the aborted access is ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, IBUSY, DBUSY};
  - localparams for default widths;
  - a port-select type {PORT_I, PORT_D}.
- One sub-module, mem_arb_watchdog: loadable counter with clear, enable and a terminal-count flag at TIMEOUT. It is reused by the team's future peripheral bridges.

Test Plan:
1. Single fetch, memory latency 0: i_req=1, i_addr=0x00000010 at cycle 0.
   - m_req=1 with m_addr=0x10 at cycle 1.
   - m_ack=1 with m_rdata=0x00500093 at cycle 1 → i_ready=1 and i_rdata=0x00500093 at cycle 1; m_req=0 at cycle 2.
2. Contention: i_req and d_req held together, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wmask=4'hF, ack latency 2.
   - Grants run D,D,D,D,I,D,...
   - m_wdata is 0xDEADBEEF on every data grant.
3. Load latency 5: d_req with d_addr=0x1004, memory returns 0x12345678 after 5 cycles.
   - d_ready is a single pulse with d_rdata=0x12345678.
   - wait_cycles increases by exactly 5.
4. Timeout, TIMEOUT=8: fetch is granted and memory never acks.
   - m_req drops after 8 BUSY cycles; err=1 and remains set; i_ready is never pulsed.
   - A later m_ack in IDLE produces no ready pulse.
5. Reset mid-transaction: assert reset=0 asynchronously during DBUSY, between clock edges.
   - m_req, d_ready and err go to 0 immediately.
   - After release, a fresh i_req completes normally.
6. Idle: no requests for 100 cycles → m_req stays 0 and wait_cycles stays 0.
